// File: rtl/pacote_zoom.sv
// Shared constants for the zoom coprocessor scan sequencer: opcodes, zoom codes,
// FSM state encodings and datapath widths.
package pacote_zoom;

  localparam int LARGURA_FONTE_PADRAO = 160;
  localparam int ALTURA_FONTE_PADRAO  = 120;
  localparam int LARG_COORD           = 10;
  localparam int LARG_END             = 19;
  localparam int LARG_ACUM            = 12;

  localparam logic [3:0] ALG_NN_AMPLIA = 4'b0001;
  localparam logic [3:0] ALG_REPLICA   = 4'b0010;
  localparam logic [3:0] ALG_NN_REDUZ  = 4'b0100;
  localparam logic [3:0] ALG_MEDIA     = 4'b1000;

  localparam logic [1:0] ZOOM_1X       = 2'b00;
  localparam logic [1:0] ZOOM_2X       = 2'b01;
  localparam logic [1:0] ZOOM_4X       = 2'b10;
  localparam logic [1:0] ZOOM_INVALIDO = 2'b11;

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] LER     = 3'd1;
  localparam logic [2:0] ACUMULA = 3'd2;
  localparam logic [2:0] ESCREVE = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;

  // Index of the last source read for one destination pixel (N-1).
  function automatic logic [3:0] ultimo_indice(input logic [3:0] alg, input logic [1:0] zm);
    logic [3:0] r;
    r = 4'd0;
    if (alg == ALG_MEDIA && zm == ZOOM_2X)
      r = 4'd3;
    else if (alg == ALG_MEDIA && zm == ZOOM_4X)
      r = 4'd15;
    return r;
  endfunction

endpackage

// File: rtl/acumulador_media.sv
// Sums the source reads of one destination pixel and scales the sum back to 8 bits
// (truncating division by 1, 4 or 16).
module acumulador_media
  import pacote_zoom::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       limpa,
  input  logic       soma,
  input  logic [1:0] desloca,
  input  logic [7:0] pixel_lido,
  output logic [7:0] media
);

  logic [LARG_ACUM-1:0] total;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      total <= '0;
    else if (limpa)
      total <= '0;
    else if (soma)
      total <= total + {4'd0, pixel_lido};
  end

  // desloca: 0 = raw sample, 1 = mean of 4, 2 = mean of 16
  always_comb begin
    case (desloca)
      2'd1:    media = total[9:2];
      2'd2:    media = total[11:4];
      default: media = total[7:0];
    endcase
  end

endmodule

// File: rtl/controlador_varredura_zoom.sv
// Raster-order scan sequencer: one destination pixel per 2N+1 cycles, issuing N source
// reads and one averaged write to the destination frame buffer.
module controlador_varredura_zoom
  import pacote_zoom::*;
#(
  parameter int LARGURA_FONTE = LARGURA_FONTE_PADRAO,
  parameter int ALTURA_FONTE  = ALTURA_FONTE_PADRAO
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iniciar,
  input  logic [3:0]            algoritmo,
  input  logic [1:0]            zoom,
  output logic [LARG_COORD-1:0] x_destino,
  output logic [LARG_COORD-1:0] y_destino,
  output logic [3:0]            indice_fonte,
  output logic                  le_mem,
  input  logic [7:0]            pixel_lido,
  output logic                  escreve_dest,
  output logic [LARG_END-1:0]   endereco_dest,
  output logic [7:0]            pixel_dest,
  output logic                  ocupado,
  output logic                  concluido,
  output logic                  erro
);

  localparam logic [LARG_COORD-1:0] W = LARG_COORD'(LARGURA_FONTE);
  localparam logic [LARG_COORD-1:0] H = LARG_COORD'(ALTURA_FONTE);

  logic [2:0]            estado;
  logic [3:0]            alg_cfg;
  logic [1:0]            zoom_cfg;
  logic [3:0]            k;
  logic [3:0]            ultimo_k;
  logic [1:0]            desloca;
  logic [LARG_COORD-1:0] largura_dest;
  logic [LARG_COORD-1:0] altura_dest;
  logic                  aceita;

  assign aceita   = (estado == OCIOSO) && iniciar && (zoom != ZOOM_INVALIDO);
  assign ultimo_k = ultimo_indice(alg_cfg, zoom_cfg);
  assign desloca  = (ultimo_k == 4'd15) ? 2'd2 : ((ultimo_k == 4'd3) ? 2'd1 : 2'd0);

  // zoom_cfg doubles as log2 of the zoom factor
  always_comb begin
    largura_dest = W;
    altura_dest  = H;
    case (alg_cfg)
      ALG_NN_AMPLIA, ALG_REPLICA: begin
        largura_dest = W << zoom_cfg;
        altura_dest  = H << zoom_cfg;
      end
      ALG_NN_REDUZ, ALG_MEDIA: begin
        largura_dest = W >> zoom_cfg;
        altura_dest  = H >> zoom_cfg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado        <= OCIOSO;
      alg_cfg       <= '0;
      zoom_cfg      <= '0;
      k             <= '0;
      x_destino     <= '0;
      y_destino     <= '0;
      endereco_dest <= '0;
      erro          <= 1'b0;
    end else begin
      erro <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar && zoom == ZOOM_INVALIDO) begin
            erro <= 1'b1;
          end else if (aceita) begin
            alg_cfg       <= algoritmo;
            zoom_cfg      <= zoom;
            k             <= '0;
            x_destino     <= '0;
            y_destino     <= '0;
            endereco_dest <= '0;
            estado        <= LER;
          end
        end
        LER: estado <= ACUMULA;
        ACUMULA: begin
          if (k != ultimo_k) begin
            k      <= k + 4'd1;
            estado <= LER;
          end else begin
            estado <= ESCREVE;
          end
        end
        ESCREVE: begin
          endereco_dest <= endereco_dest + 19'd1;
          k             <= '0;
          estado        <= LER;
          if (x_destino == largura_dest - 10'd1) begin
            x_destino <= '0;
            if (y_destino == altura_dest - 10'd1)
              estado <= FIM;
            else
              y_destino <= y_destino + 10'd1;
          end else begin
            x_destino <= x_destino + 10'd1;
          end
        end
        FIM:     estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign le_mem       = (estado == LER);
  assign escreve_dest = (estado == ESCREVE);
  assign concluido    = (estado == FIM);
  assign ocupado      = (estado == LER) || (estado == ACUMULA) || (estado == ESCREVE);
  assign indice_fonte = k;

  acumulador_media u_acumulador (
    .clk        (clk),
    .reset_n    (reset_n),
    .limpa      (aceita || (estado == ESCREVE)),
    .soma       (estado == ACUMULA),
    .desloca    (desloca),
    .pixel_lido (pixel_lido),
    .media      (pixel_dest)
  );

endmodule

// File: tb/tb_controlador_varredura_zoom.sv
// Randomized scoreboard bench for the zoom scan sequencer, run on a reduced 12x8 source
// frame so that every algorithm/zoom combination completes quickly.
module tb_controlador_varredura_zoom;

  localparam int W = 12;
  localparam int H = 8;

  logic        clk;
  logic        reset_n;
  logic        iniciar;
  logic [3:0]  algoritmo;
  logic [1:0]  zoom;
  logic [9:0]  x_destino;
  logic [9:0]  y_destino;
  logic [3:0]  indice_fonte;
  logic        le_mem;
  logic [7:0]  pixel_lido;
  logic        escreve_dest;
  logic [18:0] endereco_dest;
  logic [7:0]  pixel_dest;
  logic        ocupado;
  logic        concluido;
  logic        erro;

  typedef struct {
    int x;
    int y;
    int endereco;
    int pixel;
  } esperado_t;

  esperado_t fila[$];
  esperado_t atual;
  int comparados;
  int divergentes;
  int leituras;
  int escritas;
  int n_atual;
  int semente;

  controlador_varredura_zoom #(
    .LARGURA_FONTE (W),
    .ALTURA_FONTE  (H)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .iniciar       (iniciar),
    .algoritmo     (algoritmo),
    .zoom          (zoom),
    .x_destino     (x_destino),
    .y_destino     (y_destino),
    .indice_fonte  (indice_fonte),
    .le_mem        (le_mem),
    .pixel_lido    (pixel_lido),
    .escreve_dest  (escreve_dest),
    .endereco_dest (endereco_dest),
    .pixel_dest    (pixel_dest),
    .ocupado       (ocupado),
    .concluido     (concluido),
    .erro          (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source image content as a hash of destination coordinate and read index.
  function automatic logic [7:0] memVal(input int x, input int y, input int i);
    int h;
    h = x * 131 + y * 977 + i * 61 + semente;
    h = h ^ (h >>> 5);
    return h[7:0];
  endfunction

  task automatic checkOutput(input string nome, input int valor, input int esperado);
    comparados++;
    if (valor != esperado) begin
      divergentes++;
      $display("[TB] FAIL %s: atual=%0d esperado=%0d", nome, valor, esperado);
    end
  endtask

  // Source memory: one-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pixel_lido <= 8'd0;
    else if (le_mem)
      pixel_lido <= memVal(int'(x_destino), int'(y_destino), int'(indice_fonte));
    else
      pixel_lido <= 8'($urandom);
  end

  // Monitor: every read must belong to the pending pixel, every write pops the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (fila.size() == 0) begin
        if (le_mem)       checkOutput("le_mem_sem_pixel", int'(le_mem), 0);
        if (escreve_dest) checkOutput("escrita_extra", int'(escreve_dest), 0);
      end else begin
        if (le_mem) begin
          checkOutput("indice_fonte", int'(indice_fonte), leituras);
          checkOutput("x_leitura", int'(x_destino), fila[0].x);
          checkOutput("y_leitura", int'(y_destino), fila[0].y);
          leituras++;
        end
        if (escreve_dest) begin
          atual = fila.pop_front();
          checkOutput("x_escrita", int'(x_destino), atual.x);
          checkOutput("y_escrita", int'(y_destino), atual.y);
          checkOutput("endereco_dest", int'(endereco_dest), atual.endereco);
          checkOutput("pixel_dest", int'(pixel_dest), atual.pixel);
          checkOutput("leituras_por_pixel", leituras, n_atual);
          leituras = 0;
          escritas++;
        end
      end
    end
  end

  // Reference model: destination geometry, reads per pixel and truncated block mean.
  task automatic preparaQuadro(input logic [3:0] alg, input logic [1:0] zm,
                               output int wd, output int hd, output int n);
    int f;
    int soma;
    f = 1 << zm;
    if (alg == 4'b0001 || alg == 4'b0010) begin
      wd = W * f;
      hd = H * f;
    end else if (alg == 4'b0100 || alg == 4'b1000) begin
      wd = W / f;
      hd = H / f;
    end else begin
      wd = W;
      hd = H;
    end
    n = (alg == 4'b1000 && f >= 2) ? f * f : 1;
    semente  = int'($urandom);
    n_atual  = n;
    leituras = 0;
    escritas = 0;
    for (int y = 0; y < hd; y++)
      for (int x = 0; x < wd; x++) begin
        soma = 0;
        for (int i = 0; i < n; i++) soma += int'(memVal(x, y, i));
        fila.push_back('{x, y, y * wd + x, soma / n});
      end
  endtask

  // Returns just after the edge that accepts the start; config inputs are then scrambled.
  task automatic pulsaIniciar(input logic [3:0] alg, input logic [1:0] zm);
    @(posedge clk);
    #1;
    iniciar   = 1'b1;
    algoritmo = alg;
    zoom      = zm;
    @(posedge clk);
    #1;
    iniciar   = 1'b0;
    algoritmo = 4'($urandom);
    zoom      = 2'($urandom_range(0, 3));
  endtask

  task automatic applyStimulus(input logic [3:0] alg, input logic [1:0] zm, input bit intruso);
    int wd, hd, n, esperado, ciclos, primeira;
    bit erro_visto;
    preparaQuadro(alg, zm, wd, hd, n);
    esperado = wd * hd * (2 * n + 1);
    pulsaIniciar(alg, zm);
    @(negedge clk);
    ciclos     = 0;
    primeira   = -1;
    erro_visto = 1'b0;
    checkOutput("ocupado_inicio", int'(ocupado), 1);
    checkOutput("le_mem_inicio", int'(le_mem), 1);
    checkOutput("endereco_inicio", int'(endereco_dest), 0);
    while (!concluido && ciclos < esperado + 20) begin
      if (escreve_dest && primeira < 0) primeira = ciclos;
      if (erro) erro_visto = 1'b1;
      if (intruso) begin
        if (ciclos == 5) begin
          iniciar   = 1'b1;
          algoritmo = 4'b0001;
          zoom      = 2'd2;
        end else if (ciclos == 7) begin
          zoom = 2'd3;
        end else if (ciclos == 9) begin
          iniciar = 1'b0;
        end
      end
      @(negedge clk);
      ciclos++;
    end
    checkOutput("concluido", int'(concluido), 1);
    checkOutput("duracao_quadro", ciclos, esperado);
    checkOutput("ocupado_fim", int'(ocupado), 0);
    checkOutput("primeira_escrita", primeira, 2 * n);
    checkOutput("erro_ocupado", int'(erro_visto), 0);
    checkOutput("total_escritas", escritas, wd * hd);
    @(negedge clk);
    checkOutput("concluido_pulso", int'(concluido), 0);
    checkOutput("pendentes", fila.size(), 0);
    fila.delete();
    iniciar = 1'b0;
  endtask

  task automatic checkZeros();
    checkOutput("zero_x", int'(x_destino), 0);
    checkOutput("zero_y", int'(y_destino), 0);
    checkOutput("zero_indice", int'(indice_fonte), 0);
    checkOutput("zero_le_mem", int'(le_mem), 0);
    checkOutput("zero_escreve", int'(escreve_dest), 0);
    checkOutput("zero_endereco", int'(endereco_dest), 0);
    checkOutput("zero_pixel", int'(pixel_dest), 0);
    checkOutput("zero_ocupado", int'(ocupado), 0);
    checkOutput("zero_concluido", int'(concluido), 0);
    checkOutput("zero_erro", int'(erro), 0);
  endtask

  task automatic testaErro();
    @(negedge clk);
    iniciar   = 1'b1;
    algoritmo = 4'($urandom);
    zoom      = 2'd3;
    @(negedge clk);
    iniciar = 1'b0;
    checkOutput("erro_pulso", int'(erro), 1);
    checkOutput("erro_sem_ocupado", int'(ocupado), 0);
    @(negedge clk);
    checkOutput("erro_largura", int'(erro), 0);
    checkOutput("erro_sem_leitura", int'(le_mem), 0);
  endtask

  task automatic resetDuranteAcumula();
    int wd, hd, n, espera;
    preparaQuadro(4'b0000, 2'd0, wd, hd, n);
    pulsaIniciar(4'b0000, 2'd0);
    espera = 0;
    while (!(escritas >= 37 && le_mem) && espera < 1000) begin
      @(negedge clk);
      espera++;
    end
    checkOutput("chegou_pixel37", int'(escritas), 37);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkZeros();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_sem_escrita", int'(escreve_dest), 0);
      checkOutput("reset_sem_concluido", int'(concluido), 0);
    end
    reset_n = 1'b1;
    fila.delete();
    leituras = 0;
    escritas = 0;
  endtask

  initial begin
    comparados  = 0;
    divergentes = 0;
    leituras    = 0;
    escritas    = 0;
    n_atual     = 1;
    semente     = 0;
    iniciar     = 1'b0;
    algoritmo   = 4'd0;
    zoom        = 2'd0;
    reset_n     = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    checkZeros();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    testaErro();
    applyStimulus(4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1000, 2'd1, 1'b1);
    applyStimulus(4'b1000, 2'd2, 1'b0);
    applyStimulus(4'b0001, 2'd1, 1'b0);
    applyStimulus(4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0010, 2'd2, 1'b1);

    for (int r = 0; r < 6; r++) begin
      logic [3:0] alg;
      case ($urandom_range(0, 5))
        0:       alg = 4'b0001;
        1:       alg = 4'b0010;
        2:       alg = 4'b0100;
        3:       alg = 4'b1000;
        4:       alg = 4'b0000;
        default: alg = 4'($urandom);
      endcase
      applyStimulus(alg, 2'($urandom_range(0, 2)), 1'($urandom));
    end

    resetDuranteAcumula();
    applyStimulus(4'b1000, 2'd1, 1'b0);
    testaErro();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: atual=timeout esperado=fim");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
